// File: rtl/pipelined_segmented_adder.sv
// Segmented add/subtract: each SEG_WIDTH slice is summed in its own register stage, with the carry chained between stages.
// Latency: NSEG cycles from acceptance to out_valid; one beat per cycle.
// Backpressure: a single global enable (adv) freezes every stage while a result waits on out_ready; in_ready follows it.
module pipelined_segmented_adder #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = WIDTH / SEG_WIDTH;

    // Subtraction is performed as a + ~b + ~borrow_in.
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             adv;

    // Per-stage registers. Operands travel with each beat so that the
    // segment handled by a later stage meets the carry from the earlier one.
    logic             vld_r [NSEG];
    logic [WIDTH-1:0] a_r   [NSEG];
    logic [WIDTH-1:0] b_r   [NSEG];
    logic [WIDTH-1:0] res_r [NSEG];
    logic             cy_r  [NSEG];

    // Next-state values for each stage.
    logic             vld_in  [NSEG];
    logic [WIDTH-1:0] a_in    [NSEG];
    logic [WIDTH-1:0] b_in    [NSEG];
    logic [WIDTH-1:0] res_nxt [NSEG];
    logic             cy_nxt  [NSEG];

    logic [SEG_WIDTH:0] seg;
    logic               c_in;
    int                 p;

    assign b_eff    = sub ? ~b : b;
    assign c_eff    = sub ? ~cin : cin;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage inputs come from the ports for stage 0 and from the previous
    // stage's registers otherwise; each stage then adds its own slice.
    always_comb begin
        vld_in  = '{default: 1'b0};
        a_in    = '{default: '0};
        b_in    = '{default: '0};
        res_nxt = '{default: '0};
        cy_nxt  = '{default: 1'b0};
        seg     = '0;
        c_in    = 1'b0;
        p       = 0;
        for (int k = 0; k < NSEG; k++) begin
            p = (k > 0) ? k - 1 : 0;
            if (k == 0) begin
                vld_in[k]  = in_valid;
                a_in[k]    = a;
                b_in[k]    = b_eff;
                c_in       = c_eff;
                res_nxt[k] = '0;
            end else begin
                vld_in[k]  = vld_r[p];
                a_in[k]    = a_r[p];
                b_in[k]    = b_r[p];
                c_in       = cy_r[p];
                res_nxt[k] = res_r[p];
            end
            seg = {1'b0, a_in[k][k*SEG_WIDTH +: SEG_WIDTH]}
                + {1'b0, b_in[k][k*SEG_WIDTH +: SEG_WIDTH]}
                + {{SEG_WIDTH{1'b0}}, c_in};
            res_nxt[k][k*SEG_WIDTH +: SEG_WIDTH] = seg[SEG_WIDTH-1:0];
            cy_nxt[k] = seg[SEG_WIDTH];
        end
    end

    // Whole pipe shifts together when adv is high, holds otherwise; reset flushes all beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                vld_r[k] <= 1'b0;
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                res_r[k] <= '0;
                cy_r[k]  <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < NSEG; k++) begin
                vld_r[k] <= vld_in[k];
                a_r[k]   <= a_in[k];
                b_r[k]   <= b_in[k];
                res_r[k] <= res_nxt[k];
                cy_r[k]  <= cy_nxt[k];
            end
        end
    end

    // Last stage is the output register; overflow uses the operand sign bits carried with the beat.
    assign out_valid = vld_r[NSEG-1];
    assign sum       = res_r[NSEG-1];
    assign cout      = cy_r[NSEG-1];
    assign ovf       = (a_r[NSEG-1][WIDTH-1] == b_r[NSEG-1][WIDTH-1])
                    && (res_r[NSEG-1][WIDTH-1] != a_r[NSEG-1][WIDTH-1]);

endmodule
